// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the cache/memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W  = 32;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache-side and memory-side bus bundle for the arbiter
interface cache_mem_arbiter_if #(
    parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
    parameter int BLOCK_W = mem_arb_pkg::BLOCK_W
);
    logic               i_mem_read;
    logic [ADDR_W-1:0]  i_mem_addr;
    logic [BLOCK_W-1:0] i_mem_rdata;
    logic               i_mem_ready;

    logic               d_mem_read;
    logic               d_mem_write;
    logic [ADDR_W-1:0]  d_mem_addr;
    logic [BLOCK_W-1:0] d_mem_wdata;
    logic [BLOCK_W-1:0] d_mem_rdata;
    logic               d_mem_ready;

    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_wdata;
    logic [BLOCK_W-1:0] mem_rdata;
    logic               mem_ready;

    // slave: the arbiter itself; master: caches plus memory around it
    modport slave (
        input  i_mem_read, i_mem_addr, d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        input  mem_rdata, mem_ready,
        output i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_mem_read, i_mem_addr, d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        output mem_rdata, mem_ready,
        input  i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick with a hold-last-grant lock
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic    i_req_i,
    input  logic    i_req_d,
    input  req_id_t i_last_grant,
    input  logic    i_lock,
    output req_id_t o_pick,
    output logic    o_valid
);
    logic w_last_req;

    assign w_last_req = (i_last_grant == REQ_D) ? i_req_d : i_req_i;

    always_comb begin
        o_valid = i_req_i | i_req_d;
        o_pick  = REQ_I;
        // a lock keeps the previous winner only while it is still asking
        if (i_lock && w_last_req) begin
            o_pick = i_last_grant;
        end else if (i_req_i && !i_req_d) begin
            o_pick = REQ_I;
        end else if (i_req_d && !i_req_i) begin
            o_pick = REQ_D;
        end else if (i_req_i && i_req_d) begin
            o_pick = (i_last_grant == REQ_I) ? REQ_D : REQ_I;
        end
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one block-wide memory port between I-cache and D-cache
module cache_mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.slave  bus
);
    arb_state_t r_state;
    arb_state_t w_next_state;
    req_id_t    r_last_grant;
    req_id_t    w_next_last_grant;
    logic       r_d_lock;
    logic       w_next_d_lock;
    req_id_t    w_pick;
    logic       w_pick_valid;

    rr_pick2 u_pick (
        .i_req_i      (bus.i_mem_read),
        .i_req_d      (bus.d_mem_read | bus.d_mem_write),
        .i_last_grant (r_last_grant),
        .i_lock       (r_d_lock & bus.d_mem_read),
        .o_pick       (w_pick),
        .o_valid      (w_pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_D;
            r_d_lock     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
            r_d_lock     <= w_next_d_lock;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        w_next_d_lock     = r_d_lock;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.i_mem_ready   = 1'b0;
        bus.d_mem_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = (w_pick == REQ_I) ? GRANT_I : GRANT_D;
                end
            end
            GRANT_I: begin
                bus.mem_read    = bus.i_mem_read;
                bus.mem_addr    = bus.i_mem_addr;
                bus.i_mem_ready = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next_state      = IDLE;
                    w_next_last_grant = REQ_I;
                    w_next_d_lock     = 1'b0;
                end
            end
            GRANT_D: begin
                bus.mem_read    = bus.d_mem_read;
                bus.mem_write   = bus.d_mem_write;
                bus.mem_addr    = bus.d_mem_addr;
                bus.mem_wdata   = bus.d_mem_wdata;
                bus.d_mem_ready = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next_state      = IDLE;
                    w_next_last_grant = REQ_D;
                    // a finished write-back reserves the next slot for its allocate read
                    w_next_d_lock     = bus.d_mem_write;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign bus.i_mem_rdata = bus.mem_rdata;
    assign bus.d_mem_rdata = bus.mem_rdata;

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.d_mem_read && bus.d_mem_write));
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single 128-bit block-wide main-memory port between the instruction cache and the data cache. Each cache presents its level-held miss request (read, or data-cache write-back) and the arbiter grants one requester at a time, forwarding its request to memory and routing `mem_ready` back to it alone. Arbitration is round-robin. A data-cache write-back is locked together with the allocate read that follows it. The block sits between the two caches and the memory model / bus bridge at the top of the memory subsystem.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `BLOCK_W`, 128, cache block width (4 words).

Ports (reset rst, asynchronous, active-high; clock clk):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `i_mem_read`  in  1  instruction-cache block read request (held until `i_mem_ready`)
- `i_mem_addr`  in  ADDR_W  instruction-cache block-aligned address
- `i_mem_rdata`  out  BLOCK_W  read data to instruction cache
- `i_mem_ready`  out  1  completion strobe to instruction cache
- `d_mem_read`  in  1  data-cache allocate request
- `d_mem_write`  in  1  data-cache write-back request
- `d_mem_addr`  in  ADDR_W  data-cache block-aligned address
- `d_mem_wdata`  in  BLOCK_W  write-back data
- `d_mem_rdata`  out  BLOCK_W  read data to data cache
- `d_mem_ready`  out  1  completion strobe to data cache
- `mem_read`, `mem_write`  out  1  to memory
- `mem_addr`  out  ADDR_W  to memory
- `mem_wdata`  out  BLOCK_W  to memory
- `mem_rdata`  in  BLOCK_W  from memory
- `mem_ready`  in  1  from memory, one-cycle completion strobe

## Operation
- FSM states: `IDLE`, `GRANT_I`, `GRANT_D`. State register is `last_grant` (0 = I, 1 = D). `d_lock` is a 1-bit flag.
- `IDLE`, choosing the next grant (first matching rule wins):
  - `d_lock` set and `d_mem_read` asserted → `GRANT_D`.
  - Only one requester is asserting → grant that requester.
  - Both requesters asserting → grant the one that is not `last_grant`.
  - No request → stay in `IDLE`.
- `GRANT_x`:
  - Memory outputs equal requester x's signals combinationally. The I-side drives `mem_write = 0` and `mem_wdata = 0`.
  - `x_mem_ready = mem_ready`. The other requester's ready is held at 0.
  - On `mem_ready`: return to `IDLE` and set `last_grant = x`.
  - If the completed transaction was a D write, set `d_lock`. Otherwise clear `d_lock`.
- In `IDLE`:
  - All memory outputs are 0.
  - Both ready outputs are 0.
  - `mem_ready` is ignored.
- `i_mem_rdata` and `d_mem_rdata` both equal `mem_rdata` at all times. Only the ready strobe qualifies the data.
- A requester deasserting its request mid-grant is illegal. The grant is held until `mem_ready` regardless.
- `d_mem_read` and `d_mem_write` asserted together is illegal. The simulation assertion fires.

## Timing
- Reset values:
  - state `IDLE`.
  - `last_grant` = 1, so the first tie goes to the I side.
  - `d_lock` = 0.
  - All outputs 0.
- Reset acts asynchronously mid-transaction: memory outputs drop immediately and the transaction is abandoned.
- Grant latency:
  - A request first seen in `IDLE` in cycle N is registered at the N edge.
  - The memory request is visible in cycle N+1.
- Completion:
  - `mem_ready` in cycle M is passed to the requester in the same cycle M.
  - The FSM is in `IDLE` in cycle M+1.
  - The next memory request is visible no earlier than cycle M+2.
  - There is exactly one idle memory cycle between transactions.
- Write-back followed by allocate: the D write completes in cycle M, `d_mem_read` rises in M+1, and the D read is on memory in M+2. This holds even if `i_mem_read` has been pending throughout.
- `d_lock` is cleared by the next completed grant. The lock does not block the I side if D issues no read in `IDLE`.
- Starvation bound: with both sides continuously requesting, each side waits at most one foreign transaction, or two when a locked write-back/allocate pair is in progress.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum (`IDLE`/`GRANT_I`/`GRANT_D`).
  - `req_id_t` enum (`REQ_I`, `REQ_D`).
  - `BLOCK_W`, `ADDR_W` localparams, shared with the caches.
- Sub-module `rr_pick2`:
  - Inputs: two request bits, `last_grant`, `lock`.
  - Output: combinational pick plus a valid bit.
  - Reusable when a third requester (e.g. DMA) is added later.
- The output mux and the FSM live in the top module.

## Test plan
- Single I read at `0x0000_1000`, memory ready after 3 cycles: `mem_read` = 1 with `mem_addr` = `0x0000_1000` from cycle 1; `i_mem_ready` pulses with `mem_rdata`; `d_mem_ready` stays 0.
- I and D reads arriving in the same cycle after reset: I granted first; D granted with `mem_addr` = D address two cycles after I's ready.
- D write-back to `0x0000_2040` (wdata `0xDEAD…BEEF`) with I pending: write completes; next grant is the D allocate read at `0x0000_2080`, then I.
- Both sides requesting continuously for 8 transactions: grants alternate I,D,I,D…; no requester waits more than one transaction.
- `rst` asserted mid `GRANT_D`: `mem_write` = 0 within the same cycle; after release, the state is `IDLE` and a tie is granted to I.
- `mem_ready` pulsed while in `IDLE`: no ready is forwarded and the state is unchanged.
